// File: rtl/step_dir_if.sv
// Byte-wide configuration write port for the step/direction counter.
// The master drives the write strobe, address and data.
interface step_dir_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/step_dir.sv
// Step/direction position counter, modulo a programmable limit.
// The register map (CTRL, LIMIT low byte, LIMIT high byte) assumes WIDTH=16.
module step_dir #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             dir,
    step_dir_if.slave        bus,
    output logic [WIDTH-1:0] position,
    output logic             index,
    output logic             enabled
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] step_sync_q;
    logic [SYNC_STAGES-1:0] dir_sync_q;
    logic                   step_prev_q;
    logic                   edge_q;
    logic                   edge_d;
    logic                   edge_dir_q;
    logic [7:0]             ctrl_q;
    logic [7:0]             ctrl_d;
    logic [WIDTH-1:0]       limit_q;
    logic [WIDTH-1:0]       limit_d;
    logic [WIDTH-1:0]       pos_q;
    logic [WIDTH-1:0]       pos_d;
    logic                   idx_q;
    logic                   idx_d;

    // Synchroniser and edge detector run even while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            step_prev_q <= 1'b0;
            edge_q      <= 1'b0;
            edge_dir_q  <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step};
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir};
            step_prev_q <= step_sync_q[SYNC_STAGES-1];
            edge_q      <= edge_d;
            edge_dir_q  <= dir_sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_d = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        limit_d = limit_q;
        if (bus.wr_en) begin
            unique case (bus.wr_addr)
                2'd0: ctrl_d = bus.wr_data;
                2'd1: limit_d[7:0] = bus.wr_data;
                2'd2: limit_d[15:8] = bus.wr_data;
                2'd3: ;
            endcase
        end
    end

    // ctrl_q is the pre-write value, so a same-cycle disable still counts.
    always_comb begin
        pos_d = pos_q;
        idx_d = 1'b0;
        if (edge_q && ctrl_q[7]) begin
            if (edge_dir_q) begin
                if (pos_q >= limit_q) begin
                    pos_d = '0;
                    idx_d = 1'b1;
                end else begin
                    pos_d = pos_q + ONE;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d = limit_q;
                    idx_d = 1'b1;
                end else begin
                    pos_d = pos_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            limit_q <= '0;
            pos_q   <= '0;
            idx_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            limit_q <= limit_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
        end
    end

    assign position = pos_q;
    assign index    = idx_q;
    assign enabled  = ctrl_q[7];

endmodule

// File: tb/tb_step_dir.sv
// Randomised self-checking bench for step_dir.
// Expected position comes from a modular-counter model of the spec rules.
module tb_step_dir;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step;
    logic        dir;
    logic [15:0] position;
    logic        index;
    logic        enabled;

    step_dir_if bus();

    step_dir #(
        .WIDTH(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .step(step),
        .dir(dir),
        .bus(bus),
        .position(position),
        .index(index),
        .enabled(enabled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_pos = 0;
    int m_lim = 0;
    bit m_en = 1'b0;
    int idx_seen = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts-per-revolution model: up wraps past LIMIT, down wraps below 0.
    task automatic model_edge(input bit d, output bit idx);
        idx = 1'b0;
        if (m_en) begin
            if (d) begin
                idx = (m_pos >= m_lim);
                m_pos = idx ? 0 : m_pos + 1;
            end else begin
                idx = (m_pos == 0);
                m_pos = idx ? m_lim : m_pos - 1;
            end
        end
    endtask

    task automatic model_wr(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd0: m_en = d[7];
            2'd1: m_lim = (m_lim / 256) * 256 + int'(d);
            2'd2: m_lim = int'(d) * 256 + (m_lim % 256);
            default: ;
        endcase
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick;
        bus.wr_en = 1'b0;
        model_wr(a, d);
    endtask

    // One step pulse; optional register write lands on the update cycle.
    task automatic pulse(input bit d, input int hi, input int lo,
                         input bit do_wr, input logic [1:0] a,
                         input logic [7:0] wd, input string tag);
        int old;
        int total;
        bit eidx;
        old = m_pos;
        total = (hi + lo > 4) ? hi + lo : 4;
        dir = d;
        step = 1'b1;
        model_edge(d, eidx);
        for (int t = 1; t <= total; t++) begin
            tick;
            if (t == hi) step = 1'b0;
            if (t == 3) begin
                checks++;
                if (position !== old[15:0] || index !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early: position=%0d index=%0b expected position=%0d index=0",
                             tag, position, index, old);
                end
                if (do_wr) begin
                    bus.wr_en = 1'b1;
                    bus.wr_addr = a;
                    bus.wr_data = wd;
                end
            end
            if (t == 4) begin
                bus.wr_en = 1'b0;
                checks++;
                if (position !== m_pos[15:0] || index !== eidx) begin
                    failures++;
                    $display("FAIL %s update: position=%0d index=%0b expected position=%0d index=%0b",
                             tag, position, index, m_pos, eidx);
                end
                if (index === 1'b1) idx_seen++;
                if (do_wr) model_wr(a, wd);
            end
        end
    endtask

    task automatic up(input int n, input string tag);
        for (int i = 0; i < n; i++) pulse(1'b1, 2, 2, 1'b0, 2'd0, 8'h00, tag);
    endtask

    task automatic expect_pos(input int exp, input string tag);
        checks++;
        if (position !== exp[15:0]) begin
            failures++;
            $display("FAIL %s: position=%0d expected %0d", tag, position, exp);
        end
    endtask

    task automatic expect_idx(input int exp, input string tag);
        checks++;
        if (idx_seen != exp) begin
            failures++;
            $display("FAIL %s: index pulses=%0d expected %0d", tag, idx_seen, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (position !== 16'd0 || index !== 1'b0 || enabled !== 1'b0) begin
            failures++;
            $display("FAIL %s: position=%0d index=%0b enabled=%0b expected 0/0/0",
                     tag, position, index, enabled);
        end
        m_pos = 0;
        m_lim = 0;
        m_en = 1'b0;
        #3;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic config1999;
        wr(2'd1, 8'hCF);
        wr(2'd2, 8'h07);
        wr(2'd0, 8'h80);
        tick;
        checks++;
        if (enabled !== 1'b1) begin
            failures++;
            $display("FAIL enable_mirror: enabled=%0b expected 1", enabled);
        end
    endtask

    task automatic test_reset;
        do_reset("reset_initial");
        config1999;
        up(5, "reset_pre");
        expect_pos(5, "reset_pre_pos");
        do_reset("reset_midcount");
        tick;
        expect_pos(0, "reset_hold");
    endtask

    task automatic test_up_count;
        do_reset("upcount_reset");
        config1999;
        idx_seen = 0;
        up(100, "upcount");
        expect_pos(100, "upcount_100");
        expect_idx(0, "upcount_noidx");
    endtask

    task automatic test_up_wrap;
        up(1899, "upwrap");
        expect_pos(1999, "upwrap_1999");
        up(1, "upwrap");
        expect_pos(0, "upwrap_2000");
        up(1, "upwrap");
        expect_pos(1, "upwrap_2001");
        expect_idx(1, "upwrap_onepulse");
    endtask

    task automatic test_down_wrap;
        do_reset("down_reset");
        config1999;
        idx_seen = 0;
        pulse(1'b0, 2, 2, 1'b0, 2'd0, 8'h00, "down_wrap");
        expect_pos(1999, "down_1999");
        tick;
        checks++;
        if (index !== 1'b0) begin
            failures++;
            $display("FAIL down_idx_width: index=%0b expected 0", index);
        end
        pulse(1'b0, 2, 2, 1'b0, 2'd0, 8'h00, "down_next");
        expect_pos(1998, "down_1998");
        expect_idx(1, "down_onepulse");
    endtask

    task automatic test_disable;
        do_reset("dis_reset");
        config1999;
        up(10, "dis_pre");
        pulse(1'b1, 2, 2, 1'b1, 2'd0, 8'h00, "dis_same_cycle");
        expect_pos(11, "dis_same_cycle_pos");
        up(3, "dis_frozen");
        expect_pos(11, "dis_frozen_pos");
        dir = 1'b1;
        step = 1'b1;
        for (int i = 0; i < 6; i++) tick;
        wr(2'd0, 8'h80);
        for (int i = 0; i < 5; i++) tick;
        expect_pos(11, "dis_reenable_high");
        step = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        up(1, "dis_resume");
        expect_pos(12, "dis_resume_pos");
    endtask

    task automatic test_limit_change;
        do_reset("lim_reset");
        config1999;
        up(150, "lim_pre");
        expect_pos(150, "lim_150");
        wr(2'd1, 8'd100);
        wr(2'd2, 8'd0);
        idx_seen = 0;
        up(1, "lim_wrap");
        expect_pos(0, "lim_wrap_pos");
        expect_idx(1, "lim_wrap_idx");
    endtask

    task automatic test_limit_zero;
        do_reset("zero_reset");
        wr(2'd0, 8'h80);
        idx_seen = 0;
        for (int i = 0; i < 6; i++)
            pulse(i[0], 2, 2, 1'b0, 2'd0, 8'h00, "zero_limit");
        expect_pos(0, "zero_pos");
        expect_idx(6, "zero_idx");
    endtask

    task automatic test_random;
        logic [1:0] a;
        logic [7:0] wd;
        do_reset("rand_reset");
        wr(2'd1, 8'($urandom_range(0, 30)));
        wr(2'd0, 8'h80);
        for (int i = 0; i < 400; i++) begin
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0: wd = {($urandom_range(0, 3) != 0), 7'($urandom)};
                2'd1: wd = 8'($urandom_range(0, 40));
                2'd2: wd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
                default: wd = 8'($urandom);
            endcase
            pulse(1'($urandom), $urandom_range(2, 4), $urandom_range(2, 4),
                  ($urandom_range(0, 7) == 0), a, wd, "random");
        end
        tick;
        checks++;
        if (enabled !== m_en) begin
            failures++;
            $display("FAIL rand_enabled: enabled=%0b expected %0b", enabled, m_en);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        step = 1'b0;
        dir = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'd0;
        tick;
        tick;
        test_reset;
        test_up_count;
        test_up_wrap;
        test_down_wrap;
        test_disable;
        test_limit_change;
        test_limit_zero;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
